// File: rtl/vector_pkg.sv
// Shared types and default sizing for the vector FU sequencer.
// Covers FSM state, opcode encoding and the group descriptor.
package vector_pkg;

    localparam int DEF_LANES  = 4;
    localparam int DEF_MAX_VL = 64;
    localparam int DEF_VLW    = $clog2(DEF_MAX_VL) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    typedef enum logic [4:0] {
        VOP_ADD = 5'd0,
        VOP_SUB = 5'd1,
        VOP_MUL = 5'd2,
        VOP_AND = 5'd3,
        VOP_OR  = 5'd4,
        VOP_XOR = 5'd5,
        VOP_MAC = 5'd6
    } vfu_op_e;

    typedef struct packed {
        logic [DEF_VLW-1:0]   idx;
        logic [DEF_LANES-1:0] mask;
    } vfu_group_t;

endpackage

// File: rtl/vfu_inflight_tracker.sv
// Fixed-depth valid/payload shift register that mirrors groups in flight
// through the VFU pipe; synchronous clear drops everything still in flight.
module vfu_inflight_tracker #(
    parameter int DEPTH     = 3,
    parameter int PAYLOAD_W = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] payload_o,
    output logic                 empty_o,
    output logic                 last_o
);

    logic [DEPTH-1:0]     valid_q;
    logic [DEPTH-1:0]     valid_in;
    logic [DEPTH-1:0]     others;
    logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
    logic [PAYLOAD_W-1:0] payload_in [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_in[gi]   = push_i;
                assign payload_in[gi] = payload_i;
            end else begin : g_body
                assign valid_in[gi]   = valid_q[gi-1];
                assign payload_in[gi] = payload_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) payload_q[i] <= '0;
        end else begin
            valid_q <= clear_i ? '0 : valid_in;
            for (int i = 0; i < DEPTH; i++) payload_q[i] <= payload_in[i];
        end
    end

    // "last" means only the output stage still holds a group.
    always_comb begin
        others            = valid_q;
        others[DEPTH-1]   = 1'b0;
    end

    assign valid_o   = valid_q[DEPTH-1];
    assign payload_o = payload_q[DEPTH-1];
    assign empty_o   = (valid_q == '0);
    assign last_o    = valid_q[DEPTH-1] && (others == '0);

endmodule

// File: rtl/vector_fu_sequencer.sv
// Walks one vector command over the VFU in LANES-wide groups and tracks writebacks.
// Optional VFU_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module vector_fu_sequencer
    import vector_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int MAX_VL = DEF_MAX_VL,
    parameter int FU_LAT = 3,
    parameter int OP_W   = 5,
    parameter int REG_W  = 5,
    parameter int VLW    = $clog2(MAX_VL) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [OP_W-1:0]  cmd_op_i,
    input  logic [REG_W-1:0] cmd_vd_i,
    input  logic [REG_W-1:0] cmd_vs1_i,
    input  logic [REG_W-1:0] cmd_vs2_i,
    input  logic [VLW-1:0]   cmd_vl_i,
    input  logic             flush_i,
    output logic             fu_valid_o,
    input  logic             fu_ready_i,
    output logic [OP_W-1:0]  fu_op_o,
    output logic [REG_W-1:0] fu_vs1_o,
    output logic [REG_W-1:0] fu_vs2_o,
    output logic [VLW-1:0]   fu_idx_o,
    output logic [LANES-1:0] fu_mask_o,
    output logic             wb_valid_o,
    output logic [REG_W-1:0] wb_vd_o,
    output logic [VLW-1:0]   wb_idx_o,
    output logic [LANES-1:0] wb_mask_o,
    output logic             done_o,
    output logic             busy_o
`ifdef VFU_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_busy_cyc_o,
    output logic [31:0]      perf_stall_cyc_o
`endif
);

    localparam int PW = VLW + LANES;

    seq_state_e       state_q;
    logic [OP_W-1:0]  op_q;
    logic [REG_W-1:0] vd_q, vs1_q, vs2_q;
    logic [VLW-1:0]   vl_q, idx_q;
    logic [VLW-1:0]   vl_d, idx_d;
    logic             done_q;
    logic [LANES-1:0] lane_mask;
    logic             fu_hs, last_group;
    logic             trk_valid, trk_empty, trk_last;
    logic [PW-1:0]    trk_payload;

    assign vl_d       = (cmd_vl_i > VLW'(MAX_VL)) ? VLW'(MAX_VL) : cmd_vl_i;
    assign idx_d      = idx_q + VLW'(LANES);
    assign last_group = (idx_d >= vl_q);
    assign fu_hs      = fu_valid_o && fu_ready_i && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_mask[gi] = ((idx_q + VLW'(gi)) < vl_q);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= '0;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            vl_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_valid_i && cmd_ready_o) begin
                            op_q  <= cmd_op_i;
                            vd_q  <= cmd_vd_i;
                            vs1_q <= cmd_vs1_i;
                            vs2_q <= cmd_vs2_i;
                            vl_q  <= vl_d;
                            idx_q <= '0;
                            if (vl_d == '0) done_q  <= 1'b1;
                            else            state_q <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (fu_ready_i) begin
                            idx_q <= idx_d;
                            if (last_group) state_q <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        // Final writeback is leaving the pipe now, so done lands next cycle.
                        if (trk_last || trk_empty) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    vfu_inflight_tracker #(
        .DEPTH     (FU_LAT),
        .PAYLOAD_W (PW)
    ) u_tracker (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (flush_i),
        .push_i    (fu_hs),
        .payload_i ({idx_q, lane_mask}),
        .valid_o   (trk_valid),
        .payload_o (trk_payload),
        .empty_o   (trk_empty),
        .last_o    (trk_last)
    );

    // The done cycle still blocks new commands so one cannot overlap the pulse.
    assign cmd_ready_o = (state_q == IDLE) && !done_q && !flush_i;
    assign fu_valid_o  = (state_q == ISSUE);
    assign fu_op_o     = op_q;
    assign fu_vs1_o    = vs1_q;
    assign fu_vs2_o    = vs2_q;
    assign fu_idx_o    = idx_q;
    assign fu_mask_o   = fu_valid_o ? lane_mask : '0;
    assign wb_valid_o  = trk_valid;
    assign wb_vd_o     = vd_q;
    assign wb_idx_o    = trk_payload[PW-1:LANES];
    assign wb_mask_o   = trk_payload[LANES-1:0];
    assign done_o      = done_q;
    assign busy_o      = (state_q != IDLE);

`ifdef VFU_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_o && (perf_busy_q != '1))
                perf_busy_q <= perf_busy_q + 32'd1;
            if (fu_valid_o && !fu_ready_i && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cyc_o  = perf_busy_q;
    assign perf_stall_cyc_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_fu_sequencer.sv
// Scoreboard bench for vector_fu_sequencer: expected issues/writebacks are queued
// when a command is accepted and compared as the DUT produces them.
module tb_vector_fu_sequencer;
    import vector_pkg::*;

    localparam int LANES  = 4;
    localparam int MAX_VL = 64;
    localparam int FU_LAT = 3;
    localparam int VLW    = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [4:0]     cmd_op = '0, cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
    logic [VLW-1:0] cmd_vl = '0;
    logic           flush = 1'b0;
    logic           fu_valid;
    logic           fu_ready = 1'b1;
    logic [4:0]     fu_op, fu_vs1, fu_vs2;
    logic [VLW-1:0] fu_idx;
    logic [3:0]     fu_mask;
    logic           wb_valid;
    logic [4:0]     wb_vd;
    logic [VLW-1:0] wb_idx;
    logic [3:0]     wb_mask;
    logic           done, busy;
`ifdef VFU_SEQ_PERF_EN
    logic [31:0]    perf_busy_cyc, perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    vector_fu_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_vd_i    (cmd_vd),
        .cmd_vs1_i   (cmd_vs1),
        .cmd_vs2_i   (cmd_vs2),
        .cmd_vl_i    (cmd_vl),
        .flush_i     (flush),
        .fu_valid_o  (fu_valid),
        .fu_ready_i  (fu_ready),
        .fu_op_o     (fu_op),
        .fu_vs1_o    (fu_vs1),
        .fu_vs2_o    (fu_vs2),
        .fu_idx_o    (fu_idx),
        .fu_mask_o   (fu_mask),
        .wb_valid_o  (wb_valid),
        .wb_vd_o     (wb_vd),
        .wb_idx_o    (wb_idx),
        .wb_mask_o   (wb_mask),
        .done_o      (done),
        .busy_o      (busy)
`ifdef VFU_SEQ_PERF_EN
        ,
        .perf_busy_cyc_o  (perf_busy_cyc),
        .perf_stall_cyc_o (perf_stall_cyc)
`endif
    );

    typedef struct { vfu_group_t g; bit last; } iss_rec_t;
    typedef struct { int due; vfu_group_t g; logic [4:0] vd; bit last; } wb_rec_t;

    iss_rec_t   iss_q[$];
    wb_rec_t    wb_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_done = -1;
    bit         exp_idle = 1'b1;
    logic [4:0] exp_op = '0, exp_vd = '0, exp_vs1 = '0, exp_vs2 = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        iss_rec_t ir;
        wb_rec_t  wr;
        int       vl_eff;
        bit       exp_wb;
        bit       exp_d;
        if (rst_n) begin
            check("cmd_ready", cmd_ready, exp_idle && !flush);
            check("fu_valid", fu_valid, iss_q.size() != 0);
            if (fu_valid && iss_q.size() != 0) begin
                check("fu_idx", fu_idx, iss_q[0].g.idx);
                check("fu_mask", fu_mask, iss_q[0].g.mask);
                if (fu_ready) begin
                    ir = iss_q.pop_front();
                    check("fu_op", fu_op, exp_op);
                    check("fu_vs1", fu_vs1, exp_vs1);
                    check("fu_vs2", fu_vs2, exp_vs2);
                    wr.due  = cyc + FU_LAT;
                    wr.g    = ir.g;
                    wr.vd   = exp_vd;
                    wr.last = ir.last;
                    wb_q.push_back(wr);
                end
            end

            exp_wb = (wb_q.size() != 0) && (wb_q[0].due <= cyc);
            check("wb_valid", wb_valid, exp_wb);
            if (exp_wb) begin
                wr = wb_q.pop_front();
                if (wb_valid) begin
                    check("wb_cycle", cyc, wr.due);
                    check("wb_idx", wb_idx, wr.g.idx);
                    check("wb_mask", wb_mask, wr.g.mask);
                    check("wb_vd", wb_vd, wr.vd);
                    $display("[cyc %0d] wb vd=%0d idx=%0d mask=%b", cyc, wb_vd, wb_idx, wb_mask);
                end
                if (wr.last) exp_done = cyc + 1;
            end

            exp_d = (cyc == exp_done);
            check("done", done, exp_d);
            if (exp_d) begin
                exp_done = -1;
                exp_idle = 1'b1;
            end

            if (flush) begin
                iss_q.delete();
                wb_q.delete();
                exp_done = -1;
                exp_idle = 1'b1;
                $display("[cyc %0d] flush", cyc);
            end else if (cmd_valid && cmd_ready) begin
                vl_eff  = (int'(cmd_vl) > MAX_VL) ? MAX_VL : int'(cmd_vl);
                exp_op  = cmd_op;
                exp_vd  = cmd_vd;
                exp_vs1 = cmd_vs1;
                exp_vs2 = cmd_vs2;
                exp_idle = 1'b0;
                for (int base = 0; base < vl_eff; base += LANES) begin
                    ir.g.idx = VLW'(base);
                    for (int j = 0; j < LANES; j++) ir.g.mask[j] = (base + j < vl_eff);
                    ir.last = (base + LANES >= vl_eff);
                    iss_q.push_back(ir);
                end
                if (vl_eff == 0) exp_done = cyc + 1;
                $display("[cyc %0d] cmd op=%0d vd=%0d vs1=%0d vs2=%0d vl=%0d (eff %0d)",
                         cyc, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, vl_eff);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_fu_valid"}, fu_valid, 1'b0);
        check({tag, "_fu_idx"}, fu_idx, '0);
        check({tag, "_fu_mask"}, fu_mask, '0);
        check({tag, "_wb_valid"}, wb_valid, 1'b0);
        check({tag, "_wb_idx"}, wb_idx, '0);
        check({tag, "_wb_vd"}, wb_vd, '0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
`ifdef VFU_SEQ_PERF_EN
        check({tag, "_perf_busy"}, perf_busy_cyc, '0);
        check({tag, "_perf_stall"}, perf_stall_cyc, '0);
`endif
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                            input logic [4:0] vs2, input logic [VLW-1:0] vl);
        int n;
        n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op = op; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vl = vl;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        check("cmd_accept_in_time", n < 200, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((!exp_idle || iss_q.size() != 0 || wb_q.size() != 0 || exp_done >= 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("quiet_in_time", n < budget, 1'b1);
    endtask

    initial begin
        int n;
        // Initial reset
        #1 rst_n = 1'b0;
        #2 check_reset_values("rst0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: vl=10, full-rate issue
        send_cmd(VOP_ADD, 5'd3, 5'd1, 5'd2, 7'd10);
        wait_quiet(100);
`ifdef VFU_SEQ_PERF_EN
        check("perf_busy_t1", perf_busy_cyc, 32'd6);
`endif

        // 2: vl=0 completes without issuing
        send_cmd(VOP_SUB, 5'd4, 5'd5, 5'd6, 7'd0);
        wait_quiet(50);

        // 3: vl=8 with a 5-cycle stall on the second group
        send_cmd(VOP_MUL, 5'd7, 5'd8, 5'd9, 7'd8);
        @(posedge clk); #1 fu_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 fu_ready = 1'b1;
        wait_quiet(100);
`ifdef VFU_SEQ_PERF_EN
        check("perf_stall_t3", perf_stall_cyc, 32'd5);
`endif

        // 4: oversized vl clamps to MAX_VL; cmd_valid held high throughout
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op = VOP_XOR; cmd_vd = 5'd10; cmd_vs1 = 5'd11; cmd_vs2 = 5'd12; cmd_vl = 7'd100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        check("t4_done_in_time", n < 300, 1'b1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_quiet(50);

        // 5: flush while the first writeback emerges
        send_cmd(VOP_AND, 5'd13, 5'd14, 5'd15, 7'd16);
        @(posedge clk); #1;
        @(posedge clk); #1 fu_ready = 1'b0;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; fu_ready = 1'b1;
        repeat (FU_LAT + 2) @(posedge clk);
        wait_quiet(50);
        send_cmd(VOP_OR, 5'd16, 5'd17, 5'd18, 7'd5);
        wait_quiet(100);

        // 6: asynchronous reset mid-ISSUE
        send_cmd(VOP_MAC, 5'd19, 5'd20, 5'd21, 7'd64);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_values("rst_mid");
        iss_q.delete();
        wb_q.delete();
        exp_done = -1;
        exp_idle = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (FU_LAT + 2) @(posedge clk);
        send_cmd(VOP_ADD, 5'd22, 5'd23, 5'd24, 7'd7);
        wait_quiet(100);

        check("sb_issue_empty", iss_q.size(), 0);
        check("sb_wb_empty", wb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=%0d expected=%0d", cyc, 0);
        $fatal(1, "global timeout");
    end

endmodule
